seq_div: RTL and testbench



---
 rtl/seq_div_pkg.sv | 24 ++
 rtl/seq_div_step.sv | 26 ++
 rtl/seq_div.sv | 158 +++++++++++++++
 tb/tb_seq_div.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_div_pkg : state encoding, sign helper and divide-by-zero pattern       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the sign helper can carry; signed builds need WIDTH < c_MAXW.
    localparam int                c_MAXW     = 64;
    localparam logic [c_MAXW-1:0] c_DBZ_QUOT = '1;

    // Two's-complement negate when neg is set; gives the magnitude of a negative value.
    function automatic logic [c_MAXW-1:0] neg_if(input logic [c_MAXW-1:0] v, input logic neg);
        return neg ? (c_MAXW'(0) - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_div_step : one combinational restoring-division step                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seq_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    // The trial value keeps the bit shifted out of i_rem, so the compare never overflows.
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    assign w_trial = {i_rem, i_bit};
    assign w_diff  = w_trial - {1'b0, i_div};
    assign o_q     = (w_trial >= {1'b0, i_div});
    assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_div : multi-cycle restoring divider, one quotient bit per clock        |
// | Optional signed operands with macro SEQ_DIV_SIGNED_EN.    Rev 1.0          |
// +----------------------------------------------------------------------------+
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rmd;
    logic             r_dbz;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_q_raw;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;
    logic             w_load;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[WIDTH-1]),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_q   (w_qbit)
    );

    // The dividend register shifts out its MSB and fills with quotient bits from the right.
    assign w_q_raw = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_load  = start && (r_state != RUN) && (b != '0);

`ifdef SEQ_DIV_SIGNED_EN
    logic              r_neg_q;
    logic              r_neg_r;
    logic              w_sa;
    logic              w_sb;
    logic [c_MAXW-1:0] w_amag_x;
    logic [c_MAXW-1:0] w_bmag_x;
    logic [c_MAXW-1:0] w_q_x;
    logic [c_MAXW-1:0] w_r_x;
    logic              w_unused_hi;

    assign w_sa       = signed_mode & a[WIDTH-1];
    assign w_sb       = signed_mode & b[WIDTH-1];
    assign w_amag_x   = neg_if(c_MAXW'(a), w_sa);
    assign w_bmag_x   = neg_if(c_MAXW'(b), w_sb);
    assign w_q_x      = neg_if(c_MAXW'(w_q_raw), r_neg_q);
    assign w_r_x      = neg_if(c_MAXW'(w_rem_next), r_neg_r);
    assign w_a_mag    = w_amag_x[WIDTH-1:0];
    assign w_b_mag    = w_bmag_x[WIDTH-1:0];
    assign w_quot_fin = w_q_x[WIDTH-1:0];
    assign w_rem_fin  = w_r_x[WIDTH-1:0];
    assign w_unused_hi = ^{w_amag_x[c_MAXW-1:WIDTH], w_bmag_x[c_MAXW-1:WIDTH],
                           w_q_x[c_MAXW-1:WIDTH], w_r_x[c_MAXW-1:WIDTH]};

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_load) begin
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = signed_mode;
    assign w_a_mag       = a;
    assign w_b_mag       = b;
    assign w_quot_fin    = w_q_raw;
    assign w_rem_fin     = w_rem_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rmd   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (w_load) begin
                        r_dvd   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else if (start) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_quot  <= c_DBZ_QUOT[WIDTH-1:0];
                        r_rmd   <= a;
                        r_dbz   <= 1'b1;
                    end
                end
                RUN: begin
                    r_dvd <= w_q_raw;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_quot_fin;
                        r_rmd   <= w_rem_fin;
                        r_dbz   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rmd;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_div : directed vector table plus multi-cycle handshake sequences    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seq_div;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy, done, div_by_zero;
    logic [7:0]  quotient, remainder;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] q16, r16;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    seq_div #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .signed_mode (1'b0),
        .a           (a16),
        .b           (b16),
        .busy        (busy16),
        .done        (done16),
        .quotient    (q16),
        .remainder   (r16),
        .div_by_zero (dbz16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Drive a request at the falling edge; return #1 after the accepting rising edge.
    task automatic accept(input logic [7:0] ta, input logic [7:0] tb_, input logic sm);
        @(negedge clk);
        a = ta; b = tb_; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // lat counts rising edges from the accepting edge (=1) up to the one that raised done.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", 32'(done === 1'b1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, exp_lat;
        bit saw;

        vecs.push_back('{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0});
        vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0});
        vecs.push_back('{8'd5,   8'd9,   1'b0, 8'd0,   8'd5,   1'b0});
        vecs.push_back('{8'd77,  8'd0,   1'b0, 8'hFF,  8'd77,  1'b1});
        vecs.push_back('{8'd100, 8'd10,  1'b0, 8'd10,  8'd0,   1'b0});
        vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0});
        vecs.push_back('{8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0});
        vecs.push_back('{8'd128, 8'd2,   1'b0, 8'd64,  8'd0,   1'b0});
        vecs.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0});
        vecs.push_back('{8'd0,   8'd0,   1'b0, 8'hFF,  8'd0,   1'b1});
        vecs.push_back('{8'hF9,  8'd2,   1'b0, 8'd124, 8'd1,   1'b0});
`ifdef SEQ_DIV_SIGNED_EN
        vecs.push_back('{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0});
        vecs.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0});
        vecs.push_back('{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0});
        vecs.push_back('{8'hF9,  8'h00,  1'b1, 8'hFF,  8'hF9,  1'b1});
`else
        vecs.push_back('{8'hF9,  8'd2,   1'b1, 8'd124, 8'd1,   1'b0});
        vecs.push_back('{8'h80,  8'hFF,  1'b1, 8'd0,   8'h80,  1'b0});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quot", 32'(quotient), 0);
        chk("rst_rem",  32'(remainder), 0);
        chk("rst_dbz",  32'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].sm);
            wait_done(1, lat, bc);
            exp_lat = (vecs[i].b == 8'd0) ? 1 : W + 1;
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), (vecs[i].b == 8'd0) ? 0 : W);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
            chk($sformatf("v%0d_quot", i), 32'(quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_rem", i), 32'(remainder), 32'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            chk($sformatf("v%0d_quot_held", i), 32'(quotient), 32'(vecs[i].q));
        end
        signed_mode = 1'b0;

        // Start while busy is ignored
        accept(8'd200, 8'd7, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy", 32'(busy), 1);
        wait_done(4, lat, bc);
        chk("ign_latency", 32'(lat), W + 1);
        chk("ign_quot", 32'(quotient), 28);
        chk("ign_rem", 32'(remainder), 4);

        // Back-to-back issue during the done cycle
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_low", 32'(done), 0);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_quot_held", 32'(quotient), 28);
        wait_done(1, lat, bc);
        chk("b2b_latency", 32'(lat), W + 1);
        chk("b2b_quot", 32'(quotient), 3);
        chk("b2b_rem", 32'(remainder), 0);
        chk("b2b_dbz", 32'(div_by_zero), 0);

        // Reset in the middle of RUN with divide-by-zero results still held
        accept(8'd77, 8'd0, 1'b0);
        wait_done(1, lat, bc);
        chk("pre_rst_dbz", 32'(div_by_zero), 1);
        accept(8'd200, 8'd7, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_quot", 32'(quotient), 0);
        chk("mid_rst_rem", 32'(remainder), 0);
        chk("mid_rst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        chk("mid_rst_no_done", 32'(saw), 0);
        accept(8'd100, 8'd10, 1'b0);
        wait_done(1, lat, bc);
        chk("post_rst_latency", 32'(lat), W + 1);
        chk("post_rst_quot", 32'(quotient), 10);
        chk("post_rst_rem", 32'(remainder), 0);

        // WIDTH=16 instance
        @(negedge clk);
        a16 = 16'd60000; b16 = 16'd7; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'($urandom);
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w16_done_seen", 32'(done16 === 1'b1), 1);
        chk("w16_latency", 32'(lat), 17);
        chk("w16_quot", 32'(q16), 8571);
        chk("w16_rem", 32'(r16), 3);
        chk("w16_dbz", 32'(dbz16), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
